// File: rtl/obstacle_scheduler_if.sv
// Handshake/bus bundle between the game-control side and the obstacle scheduler.
// master: game-control side (frame timing, runner pose); slave: the scheduler.
interface obstacle_scheduler_if;
  logic       start;
  logic       frame_tick;
  logic [1:0] man_lane;
  logic       man_crouch;
  logic       man_jump;
  logic [7:0] x_out;
  logic       ld_x;
  logic       ld_shape;
  logic [1:0] top_shape;
  logic [1:0] mid_shape;
  logic [1:0] bottom_shape;
  logic       gameover;
  logic [7:0] score;
  logic [2:0] step;

  modport master (
    output start, frame_tick, man_lane, man_crouch, man_jump,
    input  x_out, ld_x, ld_shape, top_shape, mid_shape, bottom_shape,
           gameover, score, step
  );

  modport slave (
    input  start, frame_tick, man_lane, man_crouch, man_jump,
    output x_out, ld_x, ld_shape, top_shape, mid_shape, bottom_shape,
           gameover, score, step
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: scrolls the wall once per frame, re-rolls lane shapes
// from an LFSR on wrap, loads x/shapes into the pixel datapath, detects
// runner/wall collision, keeps the score and ramps the scroll speed.
module obstacle_scheduler #(
  parameter logic [7:0] X_START     = 8'd156,
  parameter logic [7:0] MAN_X       = 8'd25,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter logic [2:0] SPEED_EVERY = 3'd4,
  parameter logic [2:0] MAX_STEP    = 3'd4
) (
  input logic                  clk,
  input logic                  reset,
  obstacle_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    UPD      = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] lfsr_r;
  logic [7:0] x_r, x_nxt_s;
  logic [1:0] top_r, mid_r, bot_r;
  logic [1:0] top_nxt_s, mid_nxt_s, bot_nxt_s;
  logic [7:0] score_r, score_nxt_s;
  logic [2:0] step_r, step_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic       wrap_s;
  logic       ld_x_r, ld_shape_r, gameover_r;
  logic [1:0] lane_shape_s;
  logic       overlap_s, hit_s;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Saturating increment for the step value.
  function automatic logic [2:0] step_inc(input logic [2:0] v);
    return (v >= MAX_STEP) ? MAX_STEP : v + 3'd1;
  endfunction

  // Free-running shape generator, advances every clock outside reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_r <= SEED;
    else       lfsr_r <= lfsr_next(lfsr_r);
  end

  // Next wall position, shapes, score and speed for the coming frame.
  always_comb begin
    x_nxt_s     = x_r;
    top_nxt_s   = top_r;
    mid_nxt_s   = mid_r;
    bot_nxt_s   = bot_r;
    score_nxt_s = score_r;
    step_nxt_s  = step_r;
    cnt_nxt_s   = cnt_r;
    cnt_inc_s   = cnt_r + 3'd1;
    wrap_s      = (x_r < {5'd0, step_r});
    if (wrap_s) begin
      x_nxt_s   = X_START;
      top_nxt_s = lfsr_r[1:0];
      mid_nxt_s = lfsr_r[3:2];
      // Never emit three solid lanes: open the bottom lane instead.
      if (lfsr_r[5:0] == 6'h3F) bot_nxt_s = 2'b10;
      else                      bot_nxt_s = lfsr_r[5:4];
      if (score_r == 8'd255) score_nxt_s = score_r;
      else                   score_nxt_s = score_r + 8'd1;
      if (cnt_inc_s == SPEED_EVERY) begin
        cnt_nxt_s  = 3'd0;
        step_nxt_s = step_inc(step_r);
      end else begin
        cnt_nxt_s  = cnt_inc_s;
      end
    end else begin
      x_nxt_s = x_r - {5'd0, step_r};
    end
  end

  // Collision test of the runner against the registered wall.
  always_comb begin
    case (bus.man_lane)
      2'd0:    lane_shape_s = top_r;
      2'd1:    lane_shape_s = mid_r;
      default: lane_shape_s = bot_r;
    endcase
    overlap_s = (({1'b0, x_r} + 9'd1) >= {1'b0, MAN_X}) &&
                ({1'b0, x_r} <= ({1'b0, MAN_X} + 9'd6));
    hit_s = overlap_s &&
            ((lane_shape_s == 2'b11) ||
             ((lane_shape_s == 2'b10) && !bus.man_crouch) ||
             ((lane_shape_s[1] == 1'b0) && !bus.man_jump));
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:     if (bus.start) state_s = RUN;      else state_s = IDLE;
      RUN:      if (bus.frame_tick) state_s = UPD; else state_s = RUN;
      UPD:      if (hit_s) state_s = GAMEOVER;     else state_s = RUN;
      GAMEOVER: state_s = GAMEOVER;
      default:  state_s = IDLE;
    endcase
  end

  // State register and registered strobes decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ld_x_r     <= 1'b0;
      ld_shape_r <= 1'b0;
      gameover_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      ld_x_r     <= (state_s == UPD);
      ld_shape_r <= (state_s == UPD) && wrap_s;
      gameover_r <= (state_s == GAMEOVER);
    end
  end

  // Game registers update only on a frame tick while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r     <= X_START;
      top_r   <= 2'b00;
      mid_r   <= 2'b10;
      bot_r   <= 2'b11;
      score_r <= 8'd0;
      step_r  <= 3'd1;
      cnt_r   <= 3'd0;
    end else if ((state_r == RUN) && bus.frame_tick) begin
      x_r     <= x_nxt_s;
      top_r   <= top_nxt_s;
      mid_r   <= mid_nxt_s;
      bot_r   <= bot_nxt_s;
      score_r <= score_nxt_s;
      step_r  <= step_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign bus.x_out        = x_r;
  assign bus.ld_x         = ld_x_r;
  assign bus.ld_shape     = ld_shape_r;
  assign bus.top_shape    = top_r;
  assign bus.mid_shape    = mid_r;
  assign bus.bottom_shape = bot_r;
  assign bus.gameover     = gameover_r;
  assign bus.score        = score_r;
  assign bus.step         = step_r;

endmodule
